// File: rtl/alu_retire_unit_if.sv
// Execute-to-retire result bus: one ALU result with its destination and control tags per
// accepted valid/ready transfer.
interface alu_retire_unit_if #(
    parameter int AW = 4
) ();
    logic          ex_valid;
    logic          ex_ready;
    logic [7:0]    ex_result;
    logic          ex_cout;
    logic          ex_zero;
    logic [AW-1:0] ex_dest;
    logic          ex_wr_en;
    logic          ex_set_flags;

    modport master (
        output ex_valid,
        output ex_result,
        output ex_cout,
        output ex_zero,
        output ex_dest,
        output ex_wr_en,
        output ex_set_flags,
        input  ex_ready
    );

    modport slave (
        input  ex_valid,
        input  ex_result,
        input  ex_cout,
        input  ex_zero,
        input  ex_dest,
        input  ex_wr_en,
        input  ex_set_flags,
        output ex_ready
    );
endinterface

// File: rtl/alu_retire_unit.sv
// In-order retire buffer for ALU results: register-file write port, committed Z/C flags,
// branch condition evaluation and forwarding of pending writes to operand fetch.
module alu_retire_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_retire_unit_if.slave  ex,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [7:0]        rf_wdata,
    input  logic              rf_ready,
    input  logic [AW-1:0]     fwd_addr,
    output logic              fwd_hit,
    output logic [7:0]        fwd_data,
    input  logic [1:0]        cond_sel,
    output logic              cond_true,
    output logic              flags_busy,
    output logic              flag_z,
    output logic              flag_c
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;

    logic [7:0]    res_q   [DEPTH];
    logic          cout_q  [DEPTH];
    logic          zero_q  [DEPTH];
    logic [AW-1:0] dest_q  [DEPTH];
    logic          wr_en_q [DEPTH];
    logic          setf_q  [DEPTH];

    logic not_empty;
    logic head_writes;
    logic push;
    logic pop;

    assign not_empty   = (count_q != '0);
    assign head_writes = wr_en_q[rd_ptr_q] & (dest_q[rd_ptr_q] != '0);
    assign ex.ex_ready = (count_q != CW'(DEPTH));
    assign push        = ex.ex_valid & ex.ex_ready;
    // Entries that never touch the register file retire without waiting for the port
    assign pop         = not_empty & (~head_writes | rf_ready);

    assign rf_we    = not_empty & head_writes;
    assign rf_waddr = dest_q[rd_ptr_q];
    assign rf_wdata = res_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (setf_q[rd_ptr_q]) begin
                flag_z_d = zero_q[rd_ptr_q];
                flag_c_d = cout_q[rd_ptr_q];
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // Payload storage is qualified by count, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wr_ptr_q]   <= ex.ex_result;
            cout_q[wr_ptr_q]  <= ex.ex_cout;
            zero_q[wr_ptr_q]  <= ex.ex_zero;
            dest_q[wr_ptr_q]  <= ex.ex_dest;
            wr_en_q[wr_ptr_q] <= ex.ex_wr_en;
            setf_q[wr_ptr_q]  <= ex.ex_set_flags;
        end
    end

    // Walk from oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hit    = 1'b0;
        fwd_data   = '0;
        flags_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (setf_q[idx]) begin
                    flags_busy = 1'b1;
                end
                if (wr_en_q[idx] && (dest_q[idx] != '0) && (dest_q[idx] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = res_q[idx];
                end
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            2'b00:   cond_true = flag_z_q;
            2'b01:   cond_true = ~flag_z_q;
            2'b10:   cond_true = flag_c_q;
            default: cond_true = ~flag_c_q;
        endcase
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
endmodule

// File: tb/tb_alu_retire_unit.sv
// Directed bench for alu_retire_unit: reset, single op, backpressure, r0 retire,
// forwarding and mid-operation reset, with hand-computed expectations.
module tb_alu_retire_unit;
    logic       clk;
    logic       rst_n;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rf_ready;
    logic [3:0] fwd_addr;
    logic       fwd_hit;
    logic [7:0] fwd_data;
    logic [1:0] cond_sel;
    logic       cond_true;
    logic       flags_busy;
    logic       flag_z;
    logic       flag_c;

    int tests;
    int fails;

    alu_retire_unit_if #(.AW(4)) exb ();

    alu_retire_unit #(.DEPTH(2), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex         (exb.slave),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_ready   (rf_ready),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
        .flags_busy (flags_busy),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] res, input logic [3:0] dest, input logic wr,
                         input logic setf, input logic z, input logic c);
        exb.ex_valid     = 1'b1;
        exb.ex_result    = res;
        exb.ex_dest      = dest;
        exb.ex_wr_en     = wr;
        exb.ex_set_flags = setf;
        exb.ex_zero      = z;
        exb.ex_cout      = c;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        rf_ready = 1'b1;
        fwd_addr = 4'd0;
        cond_sel = 2'b00;
        exb.ex_valid = 1'b0;
        exb.ex_result = 8'h00;
        exb.ex_dest = 4'd0;
        exb.ex_wr_en = 1'b0;
        exb.ex_set_flags = 1'b0;
        exb.ex_zero = 1'b0;
        exb.ex_cout = 1'b0;

        // 1 reset
        tick();
        tick();
        rst_n = 1'b1;
        fwd_addr = 4'd3;
        #1;
        chk("rst_ex_ready", 16'(exb.ex_ready), 16'd1);
        chk("rst_rf_we", 16'(rf_we), 16'd0);
        chk("rst_flag_z", 16'(flag_z), 16'd0);
        chk("rst_flag_c", 16'(flag_c), 16'd0);
        chk("rst_fwd_hit", 16'(fwd_hit), 16'd0);
        chk("rst_flags_busy", 16'(flags_busy), 16'd0);

        // 2 single op
        offer(8'h5A, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        exb.ex_valid = 1'b0;
        #1;
        chk("op_rf_we", 16'(rf_we), 16'd1);
        chk("op_waddr", 16'(rf_waddr), 16'd3);
        chk("op_wdata", 16'(rf_wdata), 16'h5A);
        chk("op_fwd_hit", 16'(fwd_hit), 16'd1);
        chk("op_fwd_data", 16'(fwd_data), 16'h5A);
        chk("op_flags_busy", 16'(flags_busy), 16'd1);
        chk("op_flag_c_before", 16'(flag_c), 16'd0);
        tick();
        cond_sel = 2'b10;
        #1;
        chk("op_flag_c", 16'(flag_c), 16'd1);
        chk("op_flag_z", 16'(flag_z), 16'd0);
        chk("op_cond_c", 16'(cond_true), 16'd1);
        cond_sel = 2'b11;
        #1;
        chk("op_cond_nc", 16'(cond_true), 16'd0);
        cond_sel = 2'b01;
        #1;
        chk("op_cond_nz", 16'(cond_true), 16'd1);
        chk("op_rf_we_after", 16'(rf_we), 16'd0);

        // 3 backpressure
        rf_ready = 1'b0;
        offer(8'h11, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        offer(8'h22, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        offer(8'h33, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_ex_ready", 16'(exb.ex_ready), 16'd0);
        chk("bp_rf_we", 16'(rf_we), 16'd1);
        chk("bp_waddr_held", 16'(rf_waddr), 16'd1);
        chk("bp_wdata_held", 16'(rf_wdata), 16'h11);
        rf_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", 16'(exb.ex_ready), 16'd1);
        chk("bp_waddr2", 16'(rf_waddr), 16'd2);
        chk("bp_wdata2", 16'(rf_wdata), 16'h22);
        tick();
        exb.ex_valid = 1'b0;
        #1;
        chk("bp_waddr3", 16'(rf_waddr), 16'd4);
        chk("bp_wdata3", 16'(rf_wdata), 16'h33);
        chk("bp_rf_we3", 16'(rf_we), 16'd1);
        tick();
        chk("bp_drained_we", 16'(rf_we), 16'd0);
        chk("bp_flag_c_kept", 16'(flag_c), 16'd1);

        // 4 r0 entry retires without the write port
        rf_ready = 1'b0;
        offer(8'h77, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        fwd_addr = 4'd0;
        tick();
        exb.ex_valid = 1'b0;
        #1;
        chk("r0_rf_we", 16'(rf_we), 16'd0);
        chk("r0_busy", 16'(flags_busy), 16'd1);
        chk("r0_fwd_hit", 16'(fwd_hit), 16'd0);
        tick();
        cond_sel = 2'b00;
        #1;
        chk("r0_flag_z", 16'(flag_z), 16'd1);
        chk("r0_flag_c", 16'(flag_c), 16'd0);
        chk("r0_cond_z", 16'(cond_true), 16'd1);
        chk("r0_busy_clr", 16'(flags_busy), 16'd0);
        chk("r0_rf_we_after", 16'(rf_we), 16'd0);
        chk("r0_ex_ready", 16'(exb.ex_ready), 16'd1);

        // 5 forwarding, youngest wins
        offer(8'h11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fw_busy_none", 16'(flags_busy), 16'd0);
        offer(8'h22, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        exb.ex_valid = 1'b0;
        fwd_addr = 4'd5;
        #1;
        chk("fw_hit5", 16'(fwd_hit), 16'd1);
        chk("fw_data5", 16'(fwd_data), 16'h22);
        chk("fw_busy", 16'(flags_busy), 16'd1);
        chk("fw_head_wdata", 16'(rf_wdata), 16'h11);
        fwd_addr = 4'd0;
        #1;
        chk("fw_hit0", 16'(fwd_hit), 16'd0);
        chk("fw_data0", 16'(fwd_data), 16'h00);
        fwd_addr = 4'd6;
        #1;
        chk("fw_hit6", 16'(fwd_hit), 16'd0);
        fwd_addr = 4'd5;
        rf_ready = 1'b1;
        tick();
        chk("fw_after_pop_data", 16'(fwd_data), 16'h22);
        chk("fw_after_pop_busy", 16'(flags_busy), 16'd1);
        chk("fw_flag_z_pending", 16'(flag_z), 16'd1);
        tick();
        chk("fw_empty_hit", 16'(fwd_hit), 16'd0);
        chk("fw_empty_busy", 16'(flags_busy), 16'd0);
        chk("fw_flag_z", 16'(flag_z), 16'd0);
        chk("fw_flag_c", 16'(flag_c), 16'd1);

        // 6 mid-operation reset
        rf_ready = 1'b0;
        offer(8'h99, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        offer(8'hAA, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exb.ex_valid = 1'b0;
        fwd_addr = 4'd7;
        #1;
        chk("mr_full", 16'(exb.ex_ready), 16'd0);
        chk("mr_hit_before", 16'(fwd_hit), 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_ex_ready", 16'(exb.ex_ready), 16'd1);
        chk("mr_rf_we", 16'(rf_we), 16'd0);
        chk("mr_flag_z", 16'(flag_z), 16'd0);
        chk("mr_flag_c", 16'(flag_c), 16'd0);
        chk("mr_fwd_hit", 16'(fwd_hit), 16'd0);
        chk("mr_busy", 16'(flags_busy), 16'd0);
        rf_ready = 1'b1;
        tick();
        chk("mr_rf_we_later", 16'(rf_we), 16'd0);
        chk("mr_flag_c_later", 16'(flag_c), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
